// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM state and mode encodings for the memcopy engine
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/datamem.sv
// rtl/datamem.sv - data memory with synchronous write and combinational read
module datamem #(
   parameter int AddWidth  = 4,
   parameter int DataWidth = 8
) (
   input  logic                 CLK,
   input  logic [AddWidth-1:0]  ADD,
   input  logic [DataWidth-1:0] DATAIN,
   input  logic                 WEN,
   output logic [DataWidth-1:0] DATAOUT
);

   logic [DataWidth-1:0] mem [0:(2**AddWidth)-1];

   always_ff @(posedge CLK) begin
      if (WEN) mem[ADD] <= DATAIN;
   end

   assign DATAOUT = mem[ADD];

endmodule

// File: rtl/memcopy_engine.sv
// rtl/memcopy_engine.sv - memory master performing word copy or pattern fill jobs
module memcopy_engine
   import mem_pkg::*;
#(
   parameter int AddWidth  = 4,
   parameter int DataWidth = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic                 MODE,
   input  logic [AddWidth-1:0]  SRC,
   input  logic [AddWidth-1:0]  DST,
   input  logic [AddWidth:0]    LEN,
   input  logic [DataWidth-1:0] PATTERN,
   output logic                 BUSY,
   output logic                 DONE,
   output logic [AddWidth-1:0]  MADD,
   output logic [DataWidth-1:0] MWDATA,
   output logic                 MWEN,
   input  logic [DataWidth-1:0] MRDATA
);

   localparam logic [AddWidth:0] MaxLen = {1'b1, {AddWidth{1'b0}}};

   state_t               state;
   logic [AddWidth-1:0]  src_q;
   logic [AddWidth-1:0]  dst_q;
   logic [AddWidth:0]    cnt_q;
   logic [DataWidth-1:0] buf_q;
   logic [DataWidth-1:0] pattern_q;
   logic                 mode_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         cnt_q     <= '0;
         buf_q     <= '0;
         pattern_q <= '0;
         mode_q    <= MODE_COPY;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  src_q     <= SRC;
                  dst_q     <= DST;
                  cnt_q     <= (LEN > MaxLen) ? MaxLen : LEN;
                  mode_q    <= MODE;
                  pattern_q <= PATTERN;
                  if (LEN == '0)
                     state <= FIN;
                  else if (MODE == MODE_FILL)
                     state <= WR;
                  else
                     state <= RD;
               end
            end
            RD: begin
               buf_q <= MRDATA;
               state <= WR;
            end
            WR: begin
               dst_q <= dst_q + AddWidth'(1);
               if (mode_q == MODE_COPY) src_q <= src_q + AddWidth'(1);
               cnt_q <= cnt_q - (AddWidth+1)'(1);
               // cnt_q is never 0 here: LEN=0 bypasses straight to FIN
               if (cnt_q == (AddWidth+1)'(1))
                  state <= FIN;
               else if (mode_q == MODE_COPY)
                  state <= RD;
               else
                  state <= WR;
            end
            FIN: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign BUSY = (state != IDLE);
   assign DONE = (state == FIN);
   assign MWEN = (state == WR);

   always_comb begin
      MADD   = '0;
      MWDATA = '0;
      case (state)
         RD: MADD = src_q;
         WR: begin
            MADD   = dst_q;
            MWDATA = (mode_q == MODE_FILL) ? pattern_q : buf_q;
         end
         default: begin
            MADD   = '0;
            MWDATA = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_memcopy_engine.sv
// tb/tb_memcopy_engine.sv - self-checking bench for memcopy_engine with datamem
module tb_memcopy_engine;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       START = 1'b0;
   logic       MODE = 1'b0;
   logic [3:0] SRC = '0;
   logic [3:0] DST = '0;
   logic [4:0] LEN = '0;
   logic [7:0] PATTERN = '0;
   logic       BUSY, DONE, MWEN;
   logic [3:0] MADD;
   logic [7:0] MWDATA, MRDATA;

   memcopy_engine #(.AddWidth(4), .DataWidth(8)) u_dut (
      .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .SRC(SRC), .DST(DST),
      .LEN(LEN), .PATTERN(PATTERN), .BUSY(BUSY), .DONE(DONE), .MADD(MADD),
      .MWDATA(MWDATA), .MWEN(MWEN), .MRDATA(MRDATA)
   );

   datamem #(.AddWidth(4), .DataWidth(8)) u_mem (
      .CLK(CLK), .ADD(MADD), .DATAIN(MWDATA), .WEN(MWEN), .DATAOUT(MRDATA)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   typedef struct {
      logic       mode;
      logic [3:0] src;
      logic [3:0] dst;
      logic [4:0] len;
      logic [7:0] pat;
      int         exp_done;
   } vec_t;

   wr_t        exp_q[$];
   vec_t       vecs[7];
   logic [7:0] model [0:15];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         wr_seen = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard: every write the DUT issues must match the next expected write
   always @(negedge CLK) begin
      if (!RST && MWEN) begin
         wr_t e;
         wr_seen++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got addr %0d data %0h expected none", MADD, MWDATA);
         end else begin
            e = exp_q.pop_front();
            if (MADD !== e.addr || MWDATA !== e.data) begin
               n_bad++;
               $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                        MADD, MWDATA, e.addr, e.data);
            end
         end
      end
   end

   task automatic model_job(input logic mode, input logic [3:0] src, input logic [3:0] dst,
                            input logic [4:0] len, input logic [7:0] pat);
      int eff;
      logic [3:0] a, s;
      logic [7:0] d;
      eff = (len > 5'd16) ? 16 : int'(len);
      for (int i = 0; i < eff; i++) begin
         a = dst + 4'(i);
         s = src + 4'(i);
         d = mode ? pat : model[s];
         model[a] = d;
         exp_q.push_back('{addr: a, data: d});
      end
   endtask

   task automatic check_mem(input string name);
      int bad_addr;
      bad_addr = -1;
      for (int i = 15; i >= 0; i--)
         if (u_mem.mem[i] !== model[i]) bad_addr = i;
      n_cmp++;
      if (bad_addr >= 0) begin
         n_bad++;
         $display("FAIL %s: mem[%0d] got %0h expected %0h", name, bad_addr,
                  u_mem.mem[bad_addr], model[bad_addr]);
      end
   endtask

   task automatic run_job(input string name, input logic mode, input logic [3:0] src,
                          input logic [3:0] dst, input logic [4:0] len, input logic [7:0] pat,
                          input int exp_done, input bit intrude);
      int base, cyc, eff;
      bit got;
      eff = (len > 5'd16) ? 16 : int'(len);
      model_job(mode, src, dst, len, pat);
      base = wr_seen;
      @(negedge CLK);
      START = 1'b1; MODE = mode; SRC = src; DST = dst; LEN = len; PATTERN = pat;
      @(posedge CLK);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 100) begin
         @(negedge CLK);
         cyc++;
         START = 1'b0;
         if (intrude && cyc == 3) begin
            START = 1'b1; MODE = 1'b1; DST = 4'd0; LEN = 5'd2; PATTERN = 8'h00;
         end
         if (DONE) got = 1'b1;
      end
      check({name, "_done_cycle"}, cyc, exp_done);
      @(negedge CLK);
      check({name, "_busy_after"}, int'(BUSY), 0);
      check({name, "_write_count"}, wr_seen - base, eff);
      check({name, "_queue_left"}, exp_q.size(), 0);
      exp_q.delete();
      check_mem({name, "_mem"});
   endtask

   initial begin
      int base;
      vecs[0] = '{mode: 1'b0, src: 4'd2,  dst: 4'd9,  len: 5'd3,  pat: 8'h00, exp_done: 7};
      vecs[1] = '{mode: 1'b1, src: 4'd0,  dst: 4'd14, len: 5'd4,  pat: 8'h5A, exp_done: 5};
      vecs[2] = '{mode: 1'b1, src: 4'd0,  dst: 4'd5,  len: 5'd0,  pat: 8'hEE, exp_done: 1};
      vecs[3] = '{mode: 1'b0, src: 4'd1,  dst: 4'd6,  len: 5'd0,  pat: 8'h00, exp_done: 1};
      vecs[4] = '{mode: 1'b0, src: 4'd4,  dst: 4'd8,  len: 5'd31, pat: 8'h00, exp_done: 33};
      vecs[5] = '{mode: 1'b1, src: 4'd0,  dst: 4'd3,  len: 5'd16, pat: 8'hC3, exp_done: 17};
      vecs[6] = '{mode: 1'b0, src: 4'd15, dst: 4'd0,  len: 5'd1,  pat: 8'h00, exp_done: 3};

      for (int i = 0; i < 16; i++) model[i] = 8'h10 + 8'(i);
      model[2] = 8'hA1; model[3] = 8'hB2; model[4] = 8'hC3;
      for (int i = 0; i < 16; i++) u_mem.mem[i] = model[i];

      // Before the first clock edge: values can only come from the async reset
      #2;
      check("reset_busy", int'(BUSY), 0);
      check("reset_done", int'(DONE), 0);
      check("reset_mwen", int'(MWEN), 0);
      check("reset_madd", int'(MADD), 0);
      @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < 7; i++)
         run_job($sformatf("vec%0d", i), vecs[i].mode, vecs[i].src, vecs[i].dst,
                 vecs[i].len, vecs[i].pat, vecs[i].exp_done, 1'b0);

      run_job("busy_ignore", 1'b0, 4'd0, 4'd8, 5'd8, 8'h00, 17, 1'b1);

      @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
         model[i] = 8'(i + 1);
         u_mem.mem[i] = 8'(i + 1);
      end
      run_job("overlap", 1'b0, 4'd0, 4'd1, 5'd3, 8'h00, 7, 1'b0);
      check("overlap_word3", int'(u_mem.mem[3]), 1);

      // Reset in the second WR cycle of a fill: only the first word lands
      model[6] = 8'hFF;
      exp_q.push_back('{addr: 4'd6, data: 8'hFF});
      base = wr_seen;
      @(negedge CLK);
      START = 1'b1; MODE = 1'b1; DST = 4'd6; LEN = 5'd6; PATTERN = 8'hFF;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      @(posedge CLK);
      #2 RST = 1'b1;
      #1;
      check("midreset_mwen", int'(MWEN), 0);
      check("midreset_busy", int'(BUSY), 0);
      check("midreset_madd", int'(MADD), 0);
      @(negedge CLK);
      RST = 1'b0;
      check("midreset_writes", wr_seen - base, 1);
      check("midreset_queue", exp_q.size(), 0);
      exp_q.delete();
      check_mem("midreset_mem");

      run_job("after_reset", 1'b1, 4'd0, 4'd7, 5'd1, 8'h33, 2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/memcopy_engine.md
Name: memcopy_engine

Overview:
- Initiator-side master for the synchronous-write / combinational-read data memory (`datamem`). It drives that memory's address, write-data and write-enable ports and samples its read-data port.
- On a START command it does one of two jobs:
  - copy: moves LEN words from SRC to DST;
  - fill: writes PATTERN to LEN words starting at DST.
- When the job ends it reports DONE.
- It sits between the control unit and `datamem`. The memory's ADD, DATAIN and WEN are muxed toward this block while BUSY is high.

Parameters:
- AddWidth, 4, memory address width; must equal the `datamem` instance's AddWidth.
- DataWidth, 8, memory data width; must equal the `datamem` instance's DataWidth.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  command strobe; sampled only in IDLE.
- MODE  input  1  0 = copy, 1 = fill; latched with START.
- SRC  input  AddWidth  copy source base address; latched with START.
- DST  input  AddWidth  destination base address; latched with START.
- LEN  input  AddWidth+1  word count, 0 to 2^AddWidth; latched with START.
- PATTERN  input  DataWidth  fill value; latched with START.
- BUSY  output  1  high whenever the state is not IDLE.
- DONE  output  1  one-cycle pulse in FIN.
- MADD  output  AddWidth  memory address; connects to `datamem` ADD.
- MWDATA  output  DataWidth  memory write data; connects to `datamem` DATAIN.
- MWEN  output  1  memory write enable; connects to `datamem` WEN.
- MRDATA  input  DataWidth  memory read data; connects to `datamem` DATAOUT, combinational from MADD.

Behaviour:
- Reset: RST=1 asynchronously forces:
  - state to IDLE;
  - src_q, dst_q and cnt_q to 0;
  - buf_q to 0;
  - BUSY, DONE, MWEN, MADD and MWDATA to 0.
- Reset mid-job aborts immediately; memory words already written stay written.
- Outputs are Moore-decoded from registered state and registers, so there is no combinational path from START to MADD or MWEN.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - MWEN=0, MADD=0.
  - On START=1: latch SRC, DST, LEN, MODE and PATTERN.
  - If LEN=0, go to FIN; no memory access occurs.
  - Otherwise go to RD if MODE=0, or to WR if MODE=1.
- RD (copy only): MADD=src_q, MWEN=0, buf_q<=MRDATA at the clock edge, next state WR.
- WR:
  - MADD=dst_q, MWEN=1.
  - MWDATA is buf_q in copy mode and pattern_q in fill mode.
  - At the edge: dst_q+=1, src_q+=1 in copy mode, cnt_q-=1.
  - If cnt_q was 1, go to FIN.
  - Otherwise go to RD in copy mode, or stay in WR in fill mode.
- FIN: DONE=1, BUSY=1, MWEN=0; next state IDLE.
- Latency from START sampled at edge E0:
  - copy: 2·LEN cycles of access, DONE in cycle 2·LEN+1 after E0, BUSY low in the following cycle;
  - fill: LEN cycles, DONE in cycle LEN+1;
  - LEN=0: DONE in cycle 1.
- Address arithmetic is modulo 2^AddWidth, so addresses silently wrap from the top word to 0.
- LEN above 2^AddWidth is clamped to 2^AddWidth at latch time.
- Overlapping regions use strict forward word-by-word semantics. Example: copy with DST=SRC+1 replicates word SRC across the region. This is the specified result, not an error.
- START while BUSY=1 is ignored; it is not queued.
- START held high continuously re-triggers a new job in the first cycle after FIN returns to IDLE.
- MWDATA is 0 outside WR.

Decomposition:
- Shared package `mem_pkg`:
  - state encoding constants IDLE=2'd0, RD=2'd1, WR=2'd2, FIN=2'd3;
  - MODE_COPY=1'b0 and MODE_FILL=1'b1.
- No sub-module is required; the FSM plus the address/count registers form one block.
- The verification top instantiates `datamem` with matching parameters wired to MADD, MWDATA, MWEN and MRDATA.

Test Plan:
- Reset: RST pulse asynchronous to CLK → BUSY=0, DONE=0, MWEN=0, MADD=0 immediately, without waiting for a clock edge.
- Copy: preload mem[2..4]=8'hA1, 8'hB2, 8'hC3; START with MODE=0, SRC=2, DST=9, LEN=3 → mem[9..11]=A1, B2, C3; exactly 3 MWEN pulses; DONE 7 cycles after the START edge; source words unchanged.
- Fill with wrap: START with MODE=1, DST=14, LEN=4, PATTERN=8'h5A → mem[14], mem[15], mem[0], mem[1] all =5A; MADD sequence 14, 15, 0, 1; DONE in cycle 5.
- LEN=0 and busy-ignore:
  - LEN=0 → DONE in cycle 1, MWEN never asserted.
  - Second START during a LEN=8 copy → no effect; the first job completes unchanged.
- Overlap: mem[0..3]=01, 02, 03, 04; copy with SRC=0, DST=1, LEN=3 → mem[0..3]=01, 01, 01, 01.
- Reset mid-job: assert RST in the 2nd WR cycle of a fill of LEN=6 with PATTERN=8'hFF → only the first word is written; MWEN drops asynchronously; after release the block is IDLE and accepts a new START.
